eth_rx_frame: RTL
=================

Name: eth_rx_frame

Overview:
Receive-path framing and check stage between eth_rmii_rx and packetlogger, in the clk50 domain.
- Consumes the byte stream (data/valid/eop) from eth_rmii_rx, including preamble and SFD.
- Locates the SFD, forwards frame bytes with the 4-byte FCS stripped, and checks the CRC-32 and frame length.
- Marks each frame end with a status word, and keeps good/bad frame counters for the JTAG debug port.

Parameters:
MIN_LEN, 64, minimum legal frame length in bytes, DA through FCS inclusive.
MAX_LEN, 1518, maximum legal frame length in bytes, DA through FCS inclusive.

Ports:
clk50  in  1  50 MHz RMII clock; only clock.
reset  in  1  synchronous, active-high reset.
rxdata  in  8  byte from eth_rmii_rx.
rxvalid  in  1  rxdata valid this cycle.
rxeop  in  1  end of carrier; never coincident with rxvalid.
out_data  out  8  frame byte, FCS excluded.
out_valid  out  1  out_data valid.
out_sop  out  1  with first out_valid of a frame.
out_eop  out  1  one-cycle end-of-frame pulse; out_valid=0 that cycle.
out_status  out  3  valid with out_eop: [0] crc_err, [1] runt, [2] giant.
frames_ok  out  16  count of frames with status 0; saturates at 16'hFFFF.
frames_bad  out  16  count of frames with nonzero status; saturates at 16'hFFFF.

Behaviour:
- One clock (clk50). Reset is synchronous, active-high.
- On reset: state=HUNT; all outputs 0; counters 0; delay line emptied; CRC=32'hFFFFFFFF; length counter 0.
- State HUNT:
  - rxvalid & rxdata==8'h55: stay in HUNT.
  - rxvalid & rxdata==8'hD5: go to DATA; init CRC, length and delay line.
  - rxvalid & any other byte: go to DROP.
  - rxeop: stay in HUNT, no output.
- State DROP: ignore all bytes; rxeop -> HUNT; no outputs.
- State DATA, per byte:
  - Update CRC: reflected poly 32'hEDB88320, LSB-first, one byte per cycle.
  - Increment 11-bit length counter, saturating at 2047.
  - Push the byte into a 4-entry delay line.
  - If the line already held 4 bytes, emit the oldest: out_valid=1, out_data=that byte, registered, 1-cycle latency.
  - out_sop=1 on the first emitted byte of the frame.
- On rxeop in DATA:
  - Next cycle: out_eop=1 with out_status.
  - The (up to) 4 bytes in the delay line are the FCS and are discarded, never emitted.
  - State -> HUNT.
- Status evaluation at eop:
  - crc_err = (CRC register != 32'hDEBB20E3), the residue over data+FCS before final inversion.
  - runt = length < MIN_LEN.
  - giant = length > MAX_LEN.
- Counters: frames_ok increments when status==0, else frames_bad increments. Both update in the out_eop cycle and saturate.
- Frame with fewer than 5 bytes after SFD: no out_valid; out_eop still pulses with runt=1. out_sop is never asserted for that frame.
- Oversized frames: bytes keep being forwarded; only the giant flag is raised; the length counter saturates without wrapping.
- out_valid and out_eop are never both 1 in a cycle. Consecutive frames need no idle gap beyond the rxeop cycle.
- Reset mid-frame: in-flight frame is abandoned, no out_eop, counters cleared. Following bytes are handled by HUNT, so a mid-frame byte that is not 8'h55 or 8'hD5 leads to DROP until rxeop.

Decomposition:
- Shared package eth_pkg:
  - CRC32_POLY=32'hEDB88320, CRC32_INIT=32'hFFFFFFFF, CRC32_RESIDUE=32'hDEBB20E3.
  - Preamble byte 8'h55, SFD byte 8'hD5.
  - Status bit indices.
  - State enum {HUNT, DATA, DROP}.
- One sub-module, eth_crc32: combinational next-CRC for one byte (inputs crc[31:0], data[7:0]; output next crc[31:0]). Shared with the future eth_rmii_tx FCS generator.

Test Plan:
- Reset counters: assert reset mid-frame -> no out_eop, frames_ok=frames_bad=0, out_valid=0 next cycle.
- Runt with correct CRC: feed 55x7, D5, "123456789" (31..39), then 26 39 F4 CB, then rxeop -> out bytes 31..39 with sop on 31; out_eop with status 3'b010; frames_bad=1.
- Good minimum frame: 55x7, D5, 60 bytes 00, FCS from bench model, rxeop -> exactly 60 bytes 00 out; out_eop with status 3'b000; frames_ok=1.
- CRC error: same frame with data byte 10 flipped to 01 -> 60 bytes out; status 3'b001; frames_bad increments.
- Garbage preamble and short frames:
  - 55 55 A7 ... rxeop -> no output at all.
  - 55 D5 AA BB rxeop -> out_eop only, status runt=1 with crc_err=1 (3'b011), no out_valid.
- Giant plus back-to-back: a 1600-byte good-CRC frame -> status 3'b100 and 1596 bytes out; a good 64-byte frame immediately after rxeop -> status 0, 60 bytes out.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared constants and types for the Ethernet receive/transmit framing logic.
package eth_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    // Bit positions inside the 3-bit frame status word
    localparam int ST_CRC_ERR = 0;
    localparam int ST_RUNT    = 1;
    localparam int ST_GIANT   = 2;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        DATA = 2'd1,
        DROP = 2'd2
    } rx_state_t;

endpackage

// File: rtl/eth_crc32.sv
// Combinational CRC-32 update for one byte, reflected polynomial, LSB first.
// Also intended for the transmit-side FCS generator.
module eth_crc32
    import eth_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    // Eight serial LFSR steps unrolled into one cycle
    always_comb begin
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) c = (c >> 1) ^ CRC32_POLY;
            else      c = c >> 1;
        end
        crc_next = c;
    end

endmodule

// File: rtl/eth_rx_frame.sv
// Receive framing stage: finds the SFD, forwards frame bytes with the FCS
// stripped through a 4-byte delay line, checks CRC and length, and keeps
// good/bad frame counters.
//
// state | meaning
// HUNT  | idle or in preamble, waiting for the SFD byte
// DATA  | inside a frame, bytes go through CRC, length count and delay line
// DROP  | malformed preamble, discard everything until end of carrier
module eth_rx_frame
    import eth_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        clk50,
    input  logic        reset,
    input  logic [7:0]  rxdata,
    input  logic        rxvalid,
    input  logic        rxeop,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_sop,
    output logic        out_eop,
    output logic [2:0]  out_status,
    output logic [15:0] frames_ok,
    output logic [15:0] frames_bad
);

    localparam logic [10:0] MIN_L   = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L   = 11'(MAX_LEN);
    localparam logic [10:0] LEN_SAT = 11'h7FF;

    rx_state_t   state, state_next;
    logic [31:0] crc, crc_next;
    logic [10:0] len;
    logic [7:0]  dly [4];
    logic [2:0]  fill;
    logic        first_pending;
    logic [2:0]  status;

    eth_crc32 u_crc (
        .crc      (crc),
        .data     (rxdata),
        .crc_next (crc_next)
    );

    // Frame check result, evaluated against the registers as they stand at rxeop
    always_comb begin
        status             = 3'b000;
        status[ST_CRC_ERR] = (crc != CRC32_RESIDUE);
        status[ST_RUNT]    = (len < MIN_L);
        status[ST_GIANT]   = (len > MAX_L);
    end

    // State register
    always_ff @(posedge clk50) begin
        if (reset) state <= HUNT;
        else       state <= state_next;
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            HUNT: begin
                if (rxvalid) begin
                    if (rxdata == SFD_BYTE)           state_next = DATA;
                    else if (rxdata != PREAMBLE_BYTE) state_next = DROP;
                end
            end
            DATA:    if (rxeop) state_next = HUNT;
            DROP:    if (rxeop) state_next = HUNT;
            default: state_next = HUNT;
        endcase
    end

    // Datapath: CRC, length, delay line, registered outputs and counters
    always_ff @(posedge clk50) begin
        if (reset) begin
            crc           <= CRC32_INIT;
            len           <= 11'd0;
            fill          <= 3'd0;
            first_pending <= 1'b0;
            for (int i = 0; i < 4; i++) dly[i] <= 8'h00;
            out_data      <= 8'h00;
            out_valid     <= 1'b0;
            out_sop       <= 1'b0;
            out_eop       <= 1'b0;
            out_status    <= 3'b000;
            frames_ok     <= 16'h0000;
            frames_bad    <= 16'h0000;
        end else begin
            out_valid  <= 1'b0;
            out_sop    <= 1'b0;
            out_eop    <= 1'b0;
            out_status <= 3'b000;
            case (state)
                HUNT: begin
                    if (rxvalid && rxdata == SFD_BYTE) begin
                        crc           <= CRC32_INIT;
                        len           <= 11'd0;
                        fill          <= 3'd0;
                        first_pending <= 1'b1;
                    end
                end
                DATA: begin
                    if (rxvalid) begin
                        crc <= crc_next;
                        if (len != LEN_SAT) len <= len + 11'd1;
                        dly[0] <= rxdata;
                        dly[1] <= dly[0];
                        dly[2] <= dly[1];
                        dly[3] <= dly[2];
                        // Once four bytes are held, the oldest is known not to be FCS
                        if (fill == 3'd4) begin
                            out_valid     <= 1'b1;
                            out_data      <= dly[3];
                            out_sop       <= first_pending;
                            first_pending <= 1'b0;
                        end else begin
                            fill <= fill + 3'd1;
                        end
                    end else if (rxeop) begin
                        out_eop    <= 1'b1;
                        out_status <= status;
                        fill       <= 3'd0;
                        if (status == 3'b000) begin
                            if (frames_ok != 16'hFFFF) frames_ok <= frames_ok + 16'd1;
                        end else begin
                            if (frames_bad != 16'hFFFF) frames_bad <= frames_bad + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
